// File: rtl/cam_pixel_rx_if.sv
// Byte link (valid/data/ack four-phase) and pixel stream (valid/ready) of cam_pixel_rx.
interface cam_pixel_rx_if;
   // Four-phase byte link from the camera-FIFO transmitter
   logic        valid;
   logic [7:0]  data;
   logic        ack;
   // Pixel stream towards frame-buffer writers / loopback checkers
   logic [15:0] pix_data;
   logic        pix_valid;
   logic        pix_ready;
   logic        pix_eol;
   logic [9:0]  x_cnt;
   logic [8:0]  y_cnt;

   // Receiver side: consumes bytes, produces pixels
   modport slave (
      input  valid, data, pix_ready,
      output ack, pix_data, pix_valid, pix_eol, x_cnt, y_cnt
   );

   // Environment side: transmitter plus pixel sink
   modport master (
      output valid, data, pix_ready,
      input  ack, pix_data, pix_valid, pix_eol, x_cnt, y_cnt
   );
endinterface

// File: rtl/cam_pixel_rx.sv
// Four-phase byte receiver that pairs bytes into RGB565 pixels (MSB first) and
// streams them with x/y position, end-of-line and end-of-frame markers.
module cam_pixel_rx #(
   parameter int unsigned H_ACTIVE    = 640,
   parameter int unsigned V_ACTIVE    = 480,
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic            clk_i,
   input  logic            rst_ni,
   cam_pixel_rx_if.slave   bus,
   input  logic            frame_start_i,
   input  logic            err_clr_i,
   output logic            frame_done_o,
   output logic            sync_err_o
);

   localparam logic [9:0] XLast = 10'(H_ACTIVE - 1);
   localparam logic [8:0] YLast = 9'(V_ACTIVE - 1);

   typedef enum logic [0:0] {StIdle, StAck} state_e;

   state_e                 state_q, state_d;
   logic [SYNC_STAGES-1:0] sync_q, sync_d;
   logic [7:0]             hi_q, hi_d;
   logic                   phase_q, phase_d;
   logic [15:0]            pix_data_q, pix_data_d;
   logic                   pix_valid_q, pix_valid_d;
   logic [9:0]             x_q, x_d;
   logic [8:0]             y_q, y_d;
   logic                   frame_done_q, frame_done_d;
   logic                   sync_err_q, sync_err_d;

   logic valid_s;
   logic hs;
   logic eff_phase;

   // Synchroniser for the asynchronous valid from the transmitter
   always_comb begin
      sync_d = {sync_q[SYNC_STAGES-2:0], bus.valid};
   end

   assign valid_s = sync_q[SYNC_STAGES-1];

   // State register for FSM, synchroniser, pairing and output stream
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q      <= StIdle;
         sync_q       <= '0;
         hi_q         <= '0;
         phase_q      <= 1'b0;
         pix_data_q   <= '0;
         pix_valid_q  <= 1'b0;
         x_q          <= '0;
         y_q          <= '0;
         frame_done_q <= 1'b0;
         sync_err_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         sync_q       <= sync_d;
         hi_q         <= hi_d;
         phase_q      <= phase_d;
         pix_data_q   <= pix_data_d;
         pix_valid_q  <= pix_valid_d;
         x_q          <= x_d;
         y_q          <= y_d;
         frame_done_q <= frame_done_d;
         sync_err_q   <= sync_err_d;
      end
   end

   // Next state: stream handshake, frame alignment, then byte acceptance
   always_comb begin
      state_d      = state_q;
      hi_d         = hi_q;
      phase_d      = phase_q;
      pix_data_d   = pix_data_q;
      pix_valid_d  = pix_valid_q;
      x_d          = x_q;
      y_d          = y_q;
      frame_done_d = 1'b0;
      sync_err_d   = sync_err_q & ~err_clr_i;

      hs        = pix_valid_q & bus.pix_ready;
      // A byte taken alongside frame_start is the first byte of the new frame
      eff_phase = phase_q & ~frame_start_i;

      if (hs) begin
         pix_valid_d = 1'b0;
         if (x_q == XLast) begin
            x_d = '0;
            if (y_q == YLast) begin
               y_d          = '0;
               frame_done_d = 1'b1;
            end else begin
               y_d = y_q + 9'd1;
            end
         end else begin
            x_d = x_q + 10'd1;
         end
      end

      // Misalignment is judged after any completing handshake, so a frame that
      // ends exactly on frame_start is clean
      if (frame_start_i) begin
         if (phase_q || (x_d != '0) || (y_d != '0) || pix_valid_d) begin
            sync_err_d = 1'b1;
         end
         phase_d      = 1'b0;
         x_d          = '0;
         y_d          = '0;
         pix_valid_d  = 1'b0;
         frame_done_d = 1'b0;
      end

      case (state_q)
         StIdle: begin
            // Second byte waits until the output register is free
            if (valid_s && (!eff_phase || !pix_valid_q || bus.pix_ready)) begin
               state_d = StAck;
               if (!eff_phase) begin
                  hi_d    = bus.data;
                  phase_d = 1'b1;
               end else begin
                  pix_data_d  = {hi_q, bus.data};
                  pix_valid_d = 1'b1;
                  phase_d     = 1'b0;
               end
            end
         end
         StAck: begin
            if (!valid_s) begin
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   assign bus.ack       = (state_q == StAck);
   assign bus.pix_data  = pix_data_q;
   assign bus.pix_valid = pix_valid_q;
   assign bus.pix_eol   = (x_q == XLast);
   assign bus.x_cnt     = x_q;
   assign bus.y_cnt     = y_q;
   assign frame_done_o  = frame_done_q;
   assign sync_err_o    = sync_err_q;

endmodule

// File: tb/tb_cam_pixel_rx.sv
// Directed bench for cam_pixel_rx on a 4x2 frame with a two-stage synchroniser.
module tb_cam_pixel_rx;
   localparam int unsigned H = 4;
   localparam int unsigned V = 2;

   typedef struct {
      logic [7:0]  b0;
      logic [7:0]  b1;
      logic [15:0] exp_data;
      logic [9:0]  exp_x;
      logic [8:0]  exp_y;
      logic        exp_eol;
      logic        exp_fd;
   } vec_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic frame_start = 1'b0;
   logic err_clr = 1'b0;
   logic frame_done;
   logic sync_err;

   int n_cmp = 0;
   int n_fail = 0;
   int fd_cnt = 0;
   int pv_cycles = 0;
   logic [35:0] pq[$];
   vec_t vecs[8];

   cam_pixel_rx_if bus ();

   cam_pixel_rx #(
      .H_ACTIVE    (H),
      .V_ACTIVE    (V),
      .SYNC_STAGES (2)
   ) dut (
      .clk_i         (clk),
      .rst_ni        (rst_n),
      .bus           (bus),
      .frame_start_i (frame_start),
      .err_clr_i     (err_clr),
      .frame_done_o  (frame_done),
      .sync_err_o    (sync_err)
   );

   always #5 clk = ~clk;

   // Pixel sink monitor: inputs change just after posedge, so negedge is stable
   always @(negedge clk) begin
      if (bus.pix_valid && bus.pix_ready)
         pq.push_back({bus.pix_eol, bus.y_cnt, bus.x_cnt, bus.pix_data});
      if (bus.pix_valid) pv_cycles++;
      if (frame_done) fd_cnt++;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, required finish earlier");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [35:0] act, input logic [35:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h required %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_ack(input logic level, input string name, output int lat);
      lat = 0;
      while (bus.ack !== level && lat < 60) begin
         tick();
         lat++;
      end
      if (bus.ack !== level) begin
         n_cmp++;
         n_fail++;
         $display("FAIL %s: ack timeout got %b required %b", name, bus.ack, level);
      end
   endtask

   task automatic send_byte(input logic [7:0] b, output int lat);
      int fl;
      bus.data  = b;
      bus.valid = 1'b1;
      wait_ack(1'b1, "ack_rise", lat);
      bus.valid = 1'b0;
      wait_ack(1'b0, "ack_fall", fl);
      tick();
   endtask

   task automatic pop_pix(output logic [35:0] v);
      if (pq.size() == 0) v = 'x;
      else v = pq.pop_front();
   endtask

   task automatic pulse_fs();
      frame_start = 1'b1;
      tick();
      frame_start = 1'b0;
   endtask

   task automatic pulse_clr();
      err_clr = 1'b1;
      tick();
      err_clr = 1'b0;
   endtask

   initial begin
      int lat;
      int pv0;
      int fd0;
      logic [35:0] v;

      vecs[0] = '{8'h10, 8'h01, 16'h1001, 10'd0, 9'd0, 1'b0, 1'b0};
      vecs[1] = '{8'h20, 8'h02, 16'h2002, 10'd1, 9'd0, 1'b0, 1'b0};
      vecs[2] = '{8'h30, 8'h03, 16'h3003, 10'd2, 9'd0, 1'b0, 1'b0};
      vecs[3] = '{8'h40, 8'h04, 16'h4004, 10'd3, 9'd0, 1'b1, 1'b0};
      vecs[4] = '{8'h50, 8'h05, 16'h5005, 10'd0, 9'd1, 1'b0, 1'b0};
      vecs[5] = '{8'h60, 8'h06, 16'h6006, 10'd1, 9'd1, 1'b0, 1'b0};
      vecs[6] = '{8'h70, 8'h07, 16'h7007, 10'd2, 9'd1, 1'b0, 1'b0};
      vecs[7] = '{8'h80, 8'h08, 16'h8008, 10'd3, 9'd1, 1'b1, 1'b1};

      bus.valid     = 1'b0;
      bus.data      = 8'h00;
      bus.pix_ready = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      tick();

      // Reset state
      check("rst_ack", 36'(bus.ack), 36'd0);
      check("rst_pix_valid", 36'(bus.pix_valid), 36'd0);
      check("rst_pix_data", 36'(bus.pix_data), 36'd0);
      check("rst_eol", 36'(bus.pix_eol), 36'd0);
      check("rst_xy", 36'({bus.y_cnt, bus.x_cnt}), 36'd0);
      check("rst_frame_done", 36'(frame_done), 36'd0);
      check("rst_sync_err", 36'(sync_err), 36'd0);

      // Basic pixel, ack latency SYNC_STAGES+1
      bus.pix_ready = 1'b1;
      pv0 = pv_cycles;
      send_byte(8'hF8, lat);
      check("t1_ack_latency", 36'(lat), 36'd3);
      send_byte(8'h00, lat);
      pop_pix(v);
      check("t1_pixel", v, {1'b0, 9'd0, 10'd0, 16'hF800});
      check("t1_valid_cycles", 36'(pv_cycles - pv0), 36'd1);
      check("t1_x_after", 36'(bus.x_cnt), 36'd1);

      // Backpressure: fourth byte must wait for ready
      bus.pix_ready = 1'b0;
      send_byte(8'h12, lat);
      send_byte(8'h34, lat);
      check("t2_held_valid", 36'(bus.pix_valid), 36'd1);
      check("t2_held_data", 36'(bus.pix_data), 36'h1234);
      send_byte(8'h56, lat);
      check("t2_third_acked", 36'(lat < 60), 36'd1);
      bus.data  = 8'h78;
      bus.valid = 1'b1;
      repeat (12) tick();
      check("t2_ack_withheld", 36'(bus.ack), 36'd0);
      check("t2_still_held", 36'({bus.x_cnt, bus.pix_data}), {10'd0, 10'd1, 16'h1234});
      bus.pix_ready = 1'b1;
      wait_ack(1'b1, "t2_ack_after_ready", lat);
      bus.valid = 1'b0;
      wait_ack(1'b0, "t2_ack_fall", lat);
      tick();
      pop_pix(v);
      check("t2_pix_a", v, {1'b0, 9'd0, 10'd1, 16'h1234});
      pop_pix(v);
      check("t2_pix_b", v, {1'b0, 9'd0, 10'd2, 16'h5678});
      check("t2_queue_empty", 36'(pq.size()), 36'd0);

      // Realign to a fresh frame
      pulse_fs();
      check("realign_err", 36'(sync_err), 36'd1);
      check("realign_xy", 36'({bus.y_cnt, bus.x_cnt}), 36'd0);
      pulse_clr();
      check("realign_clr", 36'(sync_err), 36'd0);

      // Full 4x2 frame from table
      fd0 = fd_cnt;
      for (int i = 0; i < 8; i++) begin
         send_byte(vecs[i].b0, lat);
         send_byte(vecs[i].b1, lat);
         check($sformatf("t3_fd_%0d", i), 36'(fd_cnt - fd0), 36'(vecs[i].exp_fd));
      end
      for (int i = 0; i < 8; i++) begin
         pop_pix(v);
         check($sformatf("t3_pix_%0d", i), v,
               {vecs[i].exp_eol, vecs[i].exp_y, vecs[i].exp_x, vecs[i].exp_data});
      end
      check("t3_xy_end", 36'({bus.y_cnt, bus.x_cnt}), 36'd0);
      check("t3_no_err", 36'(sync_err), 36'd0);

      // frame_start mid-pixel
      send_byte(8'h11, lat);
      send_byte(8'h22, lat);
      send_byte(8'h33, lat);
      pop_pix(v);
      check("t4_pix_pre", v, {1'b0, 9'd0, 10'd0, 16'h1122});
      pulse_fs();
      check("t4_err_set", 36'(sync_err), 36'd1);
      check("t4_x_clear", 36'(bus.x_cnt), 36'd0);
      send_byte(8'hAB, lat);
      send_byte(8'hCD, lat);
      pop_pix(v);
      check("t4_pix_abcd", v, {1'b0, 9'd0, 10'd0, 16'hABCD});
      pulse_clr();
      check("t4_err_clr", 36'(sync_err), 36'd0);

      // Async reset while ack is high mid-pixel
      send_byte(8'h44, lat);
      bus.data  = 8'h55;
      bus.valid = 1'b1;
      wait_ack(1'b1, "t5_ack_rise", lat);
      #2 rst_n = 1'b0;
      #1;
      check("t5_rst_ack", 36'(bus.ack), 36'd0);
      check("t5_rst_outs", 36'({bus.pix_valid, bus.pix_data, bus.x_cnt, bus.y_cnt}), 36'd0);
      check("t5_rst_flags", 36'({frame_done, sync_err}), 36'd0);
      bus.valid = 1'b0;
      tick();
      tick();
      rst_n = 1'b1;
      tick();
      send_byte(8'h07, lat);
      send_byte(8'hE0, lat);
      pop_pix(v);
      check("t5_pix_after", v, {1'b0, 9'd0, 10'd0, 16'h07E0});

      // frame_start coincident with completion of the last pixel
      pulse_fs();
      pulse_clr();
      for (int i = 0; i < 7; i++) begin
         send_byte(8'(i), lat);
         send_byte(8'hA5, lat);
      end
      pq.delete();
      fd0 = fd_cnt;
      bus.pix_ready = 1'b0;
      send_byte(8'hC3, lat);
      send_byte(8'h3C, lat);
      check("t6_pending", 36'({bus.pix_valid, bus.y_cnt, bus.x_cnt}), {16'd0, 1'b1, 9'd1, 10'd3});
      bus.pix_ready = 1'b1;
      frame_start   = 1'b1;
      tick();
      frame_start   = 1'b0;
      tick();
      check("t6_no_frame_done", 36'(fd_cnt - fd0), 36'd0);
      check("t6_no_err", 36'(sync_err), 36'd0);
      check("t6_xy_zero", 36'({bus.pix_valid, bus.y_cnt, bus.x_cnt}), 36'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule
